// File: rtl/conv_weight_streamer_1x1.sv
// Streams 1x1 convolution weights from a synchronous-read memory into a conv layer.
// Reads walk out_ch (outer) by in_ch (inner); each returned word is re-registered before output.
module conv_weight_streamer_1x1 #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CHANNEL_NUM_IN  = 256,
  parameter int unsigned CHANNEL_NUM_OUT = 48,
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned BASE_ADDR       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  weight_rd_en,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr,
  input  logic [DATA_WIDTH-1:0] weight_rd_data,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IN_W  = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
  localparam int unsigned OUT_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IN_W-1:0]       IN_LAST  = IN_W'(CHANNEL_NUM_IN - 1);
  localparam logic [OUT_W-1:0]      OUT_LAST = OUT_W'(CHANNEL_NUM_OUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                  state;
  logic [IN_W-1:0]         in_ch;
  logic [OUT_W-1:0]        out_ch;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    reads_done;
  logic                    rd_pend;

  logic                    issue_c;
  logic                    last_c;

  // A read is issued on the accepting edge of start, and every un-held STREAM cycle until all reads are out.
  always_comb begin
    issue_c = 1'b0;
    last_c  = (in_ch == IN_LAST) && (out_ch == OUT_LAST);
    if (!hold) begin
      if (state == IDLE)
        issue_c = start;
      else if (state == STREAM)
        issue_c = !reads_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      in_ch            <= '0;
      out_ch           <= '0;
      next_addr        <= BASE;
      reads_done       <= 1'b0;
      rd_pend          <= 1'b0;
      weight_rd_en     <= 1'b0;
      weight_rd_addr   <= BASE;
      valid_weight_out <= 1'b0;
      weight_out       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      // Two-stage return path: memory latency, then the output register.
      weight_rd_en     <= issue_c;
      rd_pend          <= weight_rd_en;
      valid_weight_out <= rd_pend;
      if (rd_pend)
        weight_out <= weight_rd_data;
      done <= 1'b0;

      if (issue_c) begin
        weight_rd_addr <= next_addr;
        next_addr      <= next_addr + ADDR_WIDTH'(1);
        if (in_ch == IN_LAST) begin
          in_ch <= '0;
          if (!last_c)
            out_ch <= out_ch + OUT_W'(1);
        end else begin
          in_ch <= in_ch + IN_W'(1);
        end
        if (last_c)
          reads_done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (reads_done)
            state <= DRAIN;
        end
        DRAIN: begin
          // Final word is on the output and nothing is left in flight.
          if (!weight_rd_en && !rd_pend && valid_weight_out) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          in_ch      <= '0;
          out_ch     <= '0;
          next_addr  <= BASE;
          reads_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_weight_streamer_1x1.sv
// Directed bench for conv_weight_streamer_1x1: small 4x2 instance at base 16, plus a default-size pass.
module tb_conv_weight_streamer_1x1;

  localparam int unsigned DW   = 32;
  localparam int unsigned CIN  = 4;
  localparam int unsigned COUT = 2;
  localparam int unsigned AW   = 14;
  localparam int unsigned BASE = 16;
  localparam int unsigned NRD  = CIN * COUT;

  logic          clk = 1'b0;
  logic          reset, start, hold;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          valid;
  logic [DW-1:0] wout;
  logic          busy, done;

  logic          start_b, hold_b;
  logic          rd_en_b;
  logic [13:0]   rd_addr_b;
  logic [31:0]   rd_data_b;
  logic          valid_b;
  logic [31:0]   wout_b;
  logic          busy_b, done_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr;
  logic [31:0] exp_wout;

  int unsigned vcnt_b = 0;
  int unsigned dcnt_b = 0;
  logic [31:0] last_addr_b = '0;

  always #5 clk = ~clk;

  conv_weight_streamer_1x1 #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT),
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .weight_rd_en(rd_en), .weight_rd_addr(rd_addr), .weight_rd_data(rd_data),
    .valid_weight_out(valid), .weight_out(wout), .busy(busy), .done(done)
  );

  conv_weight_streamer_1x1 u_big (
    .clk(clk), .reset(reset), .start(start_b), .hold(hold_b),
    .weight_rd_en(rd_en_b), .weight_rd_addr(rd_addr_b), .weight_rd_data(rd_data_b),
    .valid_weight_out(valid_b), .weight_out(wout_b), .busy(busy_b), .done(done_b)
  );

  // Memory models: data word equals its address, one cycle read latency.
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= 32'(rd_addr);
    if (rd_en_b) rd_data_b <= 32'(rd_addr_b);
  end

  always @(negedge clk) begin
    if (valid_b) vcnt_b <= vcnt_b + 1;
    if (done_b)  dcnt_b <= dcnt_b + 1;
    if (rd_en_b) last_addr_b <= 32'(rd_addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int k, input logic e_rden, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_wout, input logic e_busy, input logic e_done);
    chk($sformatf("%s_k%0d_rd_en", tag, k), 32'(rd_en), 32'(e_rden));
    chk($sformatf("%s_k%0d_rd_addr", tag, k), 32'(rd_addr), e_addr);
    chk($sformatf("%s_k%0d_valid", tag, k), 32'(valid), 32'(e_valid));
    chk($sformatf("%s_k%0d_wout", tag, k), wout, e_wout);
    chk($sformatf("%s_k%0d_busy", tag, k), 32'(busy), 32'(e_busy));
    chk($sformatf("%s_k%0d_done", tag, k), 32'(done), 32'(e_done));
  endtask

  // One pass from a start at k=0. Hold is high for edges hs..he; an extra start is
  // pulsed at edge s1 and (optionally) in the cycle where done is high; reset at abort_k.
  task automatic run_pass(input string tag, input int hs, input int he, input int s1,
                          input bit start_in_done, input int abort_k);
    int   n;
    int   last;
    logic iss;
    logic e_valid;
    logic rh[$];
    logic [31:0] ah[$];
    n = 0;
    last = -1;
    for (int k = 0; k < 40; k++) begin
      hold  = (k >= hs) && (k <= he);
      start = (k == 0) || (k == s1) || (start_in_done && last >= 0 && k == last + 4);
      reset = (k == abort_k);
      step();
      if (k == abort_k) begin
        start = 1'b0;
        reset = 1'b0;
        hold  = 1'b0;
        exp_addr = BASE;
        exp_wout = '0;
        check_all({tag, "_rst"}, k, 1'b0, BASE, 1'b0, '0, 1'b0, 1'b0);
        for (int j = 1; j <= 4; j++) begin
          step();
          check_all({tag, "_post"}, k + j, 1'b0, BASE, 1'b0, '0, 1'b0, 1'b0);
        end
        return;
      end
      iss = (n < int'(NRD)) && !hold;
      if (iss) begin
        exp_addr = BASE + 32'(n);
        n++;
        if (n == int'(NRD)) last = k;
      end
      rh.push_back(iss);
      ah.push_back(exp_addr);
      e_valid = 1'b0;
      if (k >= 2) begin
        e_valid = rh[k-2];
        if (e_valid) exp_wout = ah[k-2];
      end
      check_all(tag, k, iss, exp_addr, e_valid, exp_wout,
                (last < 0) || (k <= last + 2), (last >= 0) && (k == last + 3));
      if (last >= 0 && k == last + 8) break;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    int timeout;
    reset   = 1'b1;
    start   = 1'b0;
    hold    = 1'b0;
    start_b = 1'b0;
    hold_b  = 1'b0;
    step();
    step();
    check_all("reset", 0, 1'b0, BASE, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_all("idle", 0, 1'b0, BASE, 1'b0, '0, 1'b0, 1'b0);
    exp_addr = BASE;
    exp_wout = '0;

    run_pass("basic", 100, -1, -1, 1'b0, -1);
    run_pass("hold", 3, 5, -1, 1'b0, -1);
    run_pass("abort", 100, -1, -1, 1'b0, 5);
    run_pass("after_abort", 100, -1, -1, 1'b0, -1);
    run_pass("ign_start", 100, -1, 3, 1'b1, -1);

    // Default-size pass.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    timeout = 0;
    while (!done_b && timeout < 13000) begin
      step();
      timeout++;
    end
    chk("big_done_seen", 32'(done_b), 32'd1);
    repeat (4) step();
    chk("big_valid_count", vcnt_b, 32'd12288);
    chk("big_last_addr", last_addr_b, 32'd12287);
    chk("big_done_count", dcnt_b, 32'd1);
    chk("big_busy_after", 32'(busy_b), 32'd0);
    chk("big_wout_last", wout_b, 32'd12287);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
